// File: rtl/uart_pkg.sv
// UART transmitter shared types and constants.
// Frame-control (LCR) bundle, FSM encoding and bit timing.
package uart_pkg;

  localparam int TICKS_PER_BIT   = 16;
  localparam int STOP_HALF_EXTRA = 8;
  localparam int TICK_W          = 5;
  localparam int BIT_W           = 3;
  localparam int DATA_W          = 8;
  localparam int WLS_W           = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  typedef struct packed {
    logic [WLS_W-1:0] wls;
    logic             stb;
    logic             pen;
    logic             eps;
    logic             sp;
  } lcr_t;

  // Index of the final tick of the stop period: 16, 24 or 32 ticks.
  function automatic logic [TICK_W-1:0] stop_last(input lcr_t l);
    int n;
    n = TICKS_PER_BIT;
    if (l.stb) begin
      n = (l.wls == '0) ? TICKS_PER_BIT + STOP_HALF_EXTRA
                        : 2 * TICKS_PER_BIT;
    end
    return TICK_W'(n - 1);
  endfunction

  function automatic logic parity_bit(input logic x, input lcr_t l);
    if (l.sp) return !l.eps;
    return l.eps ? x : !x;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops a FWFT FIFO and
// serialises start, 5-8 data, optional parity and stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
(
  input  logic              apb_clk_in,
  input  logic              apb_rst_in,
  input  logic              bclk_in,
  input  logic              utrst_in,
  input  logic [WLS_W-1:0]  wls_in,
  input  logic              stb_in,
  input  logic              pen_in,
  input  logic              eps_in,
  input  logic              sp_in,
  input  logic              bc_in,
  input  logic              fifo_empty_in,
  input  logic [DATA_W-1:0] fifo_data_in,
  output logic              fifo_rd_out,
  output logic              uart_txd_out,
  output logic              temt_out
);

  state_e              state_q;
  logic [TICK_W-1:0]   tick_q;
  logic [BIT_W-1:0]    bit_q;
  logic [DATA_W-1:0]   shift_q;
  logic                par_q;
  lcr_t                lcr_q;
  logic                txd_q;

  lcr_t                lcr_d;
  logic [TICK_W-1:0]   last_tick;
  logic                bit_done;
  logic                data_last;
  logic                pop;

  assign lcr_d = {wls_in, stb_in, pen_in, eps_in, sp_in};

  always_comb begin
    last_tick = TICK_W'(TICKS_PER_BIT - 1);
    if (state_q == ST_STOP) last_tick = stop_last(lcr_q);
    bit_done  = bclk_in && (tick_q == last_tick);
    data_last = bit_q == (BIT_W'(4) + BIT_W'(lcr_q.wls));
    // Pop in idle, or on the final stop tick for back-to-back frames.
    pop = !apb_rst_in && utrst_in && !fifo_empty_in &&
          ((state_q == ST_IDLE) ||
           ((state_q == ST_STOP) && bit_done));
  end

  assign fifo_rd_out  = pop;
  assign temt_out     = (state_q == ST_IDLE) && !pop;
  assign uart_txd_out = bc_in ? 1'b0 : txd_q;

  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      lcr_q   <= '0;
      txd_q   <= 1'b1;
    end else if (!utrst_in) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
    end else if (pop) begin
      state_q <= ST_START;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= fifo_data_in;
      lcr_q   <= lcr_d;
      par_q   <= 1'b0;
      txd_q   <= 1'b0;
    end else begin
      if (bclk_in && state_q != ST_IDLE) tick_q <= tick_q + 1'b1;
      if (bit_done) tick_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          tick_q <= '0;
          txd_q  <= 1'b1;
        end
        ST_START: begin
          if (bit_done) begin
            state_q <= ST_DATA;
            txd_q   <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            par_q   <= par_q ^ shift_q[0];
            shift_q <= shift_q >> 1;
            if (data_last) begin
              bit_q <= '0;
              if (lcr_q.pen) begin
                state_q <= ST_PARITY;
                txd_q   <= parity_bit(par_q ^ shift_q[0], lcr_q);
              end else begin
                state_q <= ST_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
              txd_q <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            state_q <= ST_STOP;
            txd_q   <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            state_q <= ST_IDLE;
            txd_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: expected line
// segments are queued on push and checked by a monitor.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bclk = 1'b0;
  logic       utrst = 1'b0;
  logic [1:0] wls = 2'd3;
  logic       stb = 1'b0;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sp = 1'b0;
  logic       bc = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] fdata = 8'h00;
  logic       rd;
  logic       txd;
  logic       temt;

  uart_tx_ctrl dut (
    .apb_clk_in    (clk),
    .apb_rst_in    (rst),
    .bclk_in       (bclk),
    .utrst_in      (utrst),
    .wls_in        (wls),
    .stb_in        (stb),
    .pen_in        (pen),
    .eps_in        (eps),
    .sp_in         (sp),
    .bc_in         (bc),
    .fifo_empty_in (empty),
    .fifo_data_in  (fdata),
    .fifo_rd_out   (rd),
    .uart_txd_out  (txd),
    .temt_out      (temt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [11:0] lvl;
    int          tk [12];
  } frame_t;

  frame_t     exp_q [$];
  logic [7:0] fifo_q [$];
  int         vecs = 0;
  int         errs = 0;
  int         pops_seen = 0;
  int         pops_done = 0;
  bit         armed = 1'b0;
  bit         active = 1'b0;
  frame_t     cur;
  int         seg = 0;
  int         cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  function automatic frame_t mk_frame(input logic [7:0] d);
    frame_t f;
    int nb;
    int ones;
    logic p;
    f.n = 0;
    f.lvl = '0;
    for (int i = 0; i < 12; i++) f.tk[i] = 0;
    nb = 5 + int'(wls);
    ones = 0;
    f.lvl[f.n] = 1'b0; f.tk[f.n] = 16; f.n++;
    for (int i = 0; i < nb; i++) begin
      f.lvl[f.n] = d[i]; f.tk[f.n] = 16; f.n++;
      ones += int'(d[i]);
    end
    if (pen) begin
      if (sp) p = !eps;
      else if (eps) p = (ones % 2) == 1;
      else p = (ones % 2) == 0;
      f.lvl[f.n] = p; f.tk[f.n] = 16; f.n++;
    end
    f.lvl[f.n] = 1'b1;
    f.tk[f.n] = !stb ? 16 : (wls == 2'd0 ? 24 : 32);
    f.n++;
    return f;
  endfunction

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(mk_frame(d));
  endtask

  initial begin
    @(posedge clk);
    armed = 1'b1;
  end

  // 16x tick source with random idle gaps between pulses.
  initial begin
    int gap;
    gap = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bclk) begin
        bclk = 1'b0;
        gap = $urandom_range(0, 2);
      end else if (gap == 0) begin
        bclk = 1'b1;
      end else begin
        gap--;
      end
    end
  end

  // FWFT FIFO model; pops land just after the edge that consumed the word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (pops_done < pops_seen) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        pops_done++;
      end
      #1;
      empty = fifo_q.size() == 0;
      fdata = empty ? 8'h00 : fifo_q[0];
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (rd) begin
        chk("rd_legal", int'(empty || !utrst || rst), 0);
      end
      if (active) begin
        chk("txd_frame", int'(txd), bc ? 0 : int'(cur.lvl[seg]));
        chk("temt_busy", int'(temt), 0);
        if (rst || !utrst) begin
          active = 1'b0;
        end else begin
          if (bclk) cnt++;
          if (cnt == cur.tk[seg]) begin
            seg++;
            cnt = 0;
            if (seg == cur.n) active = 1'b0;
          end
        end
      end else begin
        chk("txd_idle", int'(txd), bc ? 0 : 1);
        chk("temt_idle", int'(temt), int'(!rd));
      end
      if (rd) begin
        pops_seen++;
        chk("pop_mid_frame", int'(active), 0);
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          active = 1'b1;
          seg = 0;
          cnt = 0;
        end
      end
    end
  end

  task automatic wait_pop();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd && n < 2000);
    if (!rd) chk("wait_pop_timeout", 1, 0);
  endtask

  task automatic wait_ticks(input int t);
    int k;
    k = 0;
    while (k < t) begin
      @(negedge clk);
      if (bclk) k++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((fifo_q.size() != 0 || active || exp_q.size() != 0
                || !temt) && n < 20000);
    chk("idle_reached", int'(n < 20000), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_lcr(input logic [1:0] w, input logic s,
                         input logic p, input logic e, input logic k);
    wls = w; stb = s; pen = p; eps = e; sp = k;
  endtask

  initial begin
    int p0;
    int nw;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", int'(txd), 1);
    chk("rst_temt", int'(temt), 1);
    chk("rst_rd", int'(rd), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    utrst = 1'b1;

    set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'h55);
    wait_idle();

    set_lcr(2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h41);
    wait_idle();

    set_lcr(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'h1F);
    wait_idle();
    set_lcr(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'h1F);
    wait_idle();

    set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    p0 = pops_seen;
    push(8'hA5);
    push(8'h3C);
    wait_idle();
    chk("b2b_pops", pops_seen - p0, 2);

    push(8'hC6);
    wait_pop();
    wait_ticks(16 + 48 + 4);
    @(posedge clk); #1;
    bc = 1'b1;
    wait_ticks(40);
    @(posedge clk); #1;
    bc = 1'b0;
    wait_idle();

    p0 = pops_seen;
    push(8'h96);
    wait_pop();
    wait_ticks(16 + 32 + 5);
    @(posedge clk); #1;
    utrst = 1'b0;
    push(8'h69);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_pop", pops_seen - p0, 1);
    utrst = 1'b1;
    wait_idle();

    set_lcr(2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    push(8'h5A);
    wait_pop();
    wait_ticks(16 + 128 + 5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_txd", int'(txd), 1);
    chk("midrst_temt", int'(temt), 1);
    chk("midrst_rd", int'(rd), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      set_lcr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      nw = $urandom_range(1, 3);
      for (int j = 0; j < nw; j++) push(8'($urandom));
      while (fifo_q.size() != 0) begin
        @(posedge clk); #1;
      end
      // Scramble LCR while the last word is still on the line.
      set_lcr(2'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom));
      if ((i % 4) == 3) wait_idle();
    end
    wait_idle();
    chk("exp_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
